// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_pipe
//  Description : Clocked instruction memory with a registered read pipeline
//                (RD_LAT = 1 or 2) and a valid/ready fetch/return handshake
//                with stall and flush. A load port writes words at run time.
//                Optional macro INSTR_MEM_PARITY_EN adds a per-word even
//                parity bit and the par_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_pipe #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 256,
  parameter int                 RD_LAT    = 1,
  parameter logic [DATA_W-1:0]  HALT_WORD = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_oob,
`ifdef INSTR_MEM_PARITY_EN
  output logic              par_err,
`endif
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  // Index width of the implemented array; DEPTH never exceeds 2**ADDR_W.
  localparam int                c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_DEPTH_X = (ADDR_W + 1)'(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int                c_MEM_W   = DATA_W + 1;
  localparam logic [c_MEM_W-1:0] c_FILL   = {^HALT_WORD, HALT_WORD};
`else
  localparam int                c_MEM_W   = DATA_W;
  localparam logic [c_MEM_W-1:0] c_FILL   = HALT_WORD;
`endif

  // Storage is filled at power-up only; rst never touches it.
  logic [c_MEM_W-1:0] r_mem [DEPTH] = '{default: c_FILL};

  // Pipeline stages; index RD_LAT-1 is the output register.
  logic              r_vld   [RD_LAT];
  logic [DATA_W-1:0] r_instr [RD_LAT];
  logic [ADDR_W-1:0] r_pc    [RD_LAT];
  logic              r_oob   [RD_LAT];
  logic              r_perr  [RD_LAT];

  logic              w_adv;
  logic              w_accept;
  logic              w_fetch_in;
  logic              w_ld_in;
  logic              w_bypass;
  logic [c_MEM_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_instr0;
  logic              w_perr0;

  // Handshake: the whole pipeline moves whenever the output slot is free.
  assign w_adv       = !out_valid || out_ready;
  assign fetch_ready = w_adv;
  assign w_accept    = fetch_req && w_adv && !flush;

  // Read path: range check, write-first bypass, and parity recheck.
  always_comb begin
    w_fetch_in = ({1'b0, fetch_addr} < c_DEPTH_X);
    w_ld_in    = ({1'b0, ld_addr} < c_DEPTH_X);
    w_bypass   = ld_en && w_ld_in && (ld_addr == fetch_addr);
    w_rd_word  = r_mem[fetch_addr[c_IDX_W-1:0]];
    w_instr0   = HALT_WORD;
    w_perr0    = 1'b0;
    if (w_fetch_in) begin
      if (w_bypass) begin
        w_instr0 = ld_data;
      end else begin
        w_instr0 = w_rd_word[DATA_W-1:0];
        // Stored parity makes the whole word even; odd means corruption.
        w_perr0  = ^w_rd_word;
      end
    end
  end

  // Load port: writes every cycle it is enabled, out-of-range ignored.
  always_ff @(posedge clk) begin
    if (ld_en && w_ld_in) begin
`ifdef INSTR_MEM_PARITY_EN
      r_mem[ld_addr[c_IDX_W-1:0]] <= {^ld_data, ld_data};
`else
      r_mem[ld_addr[c_IDX_W-1:0]] <= ld_data;
`endif
    end
  end

  // Pipeline registers: flush beats stall, all stages move or hold together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i]   <= 1'b0;
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_oob[i]   <= 1'b0;
        r_perr[i]  <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld[0]   <= w_accept;
      r_instr[0] <= w_instr0;
      r_pc[0]    <= fetch_addr;
      r_oob[0]   <= !w_fetch_in;
      r_perr[0]  <= w_perr0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_instr[i] <= r_instr[i-1];
        r_pc[i]    <= r_pc[i-1];
        r_oob[i]   <= r_oob[i-1];
        r_perr[i]  <= r_perr[i-1];
      end
    end
  end

  assign out_valid = r_vld[RD_LAT-1];
  assign out_instr = r_instr[RD_LAT-1];
  assign out_pc    = r_pc[RD_LAT-1];
  assign out_oob   = r_oob[RD_LAT-1];
`ifdef INSTR_MEM_PARITY_EN
  assign par_err   = r_perr[RD_LAT-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_pipe
//  Description : Scoreboard bench driving two instr_mem_pipe instances
//                (RD_LAT=1 and RD_LAT=2, DEPTH=200) with identical directed
//                stimulus; each lane has its own expected queue and monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_mem_pipe;
  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int DEP = 200;

  typedef struct {
    logic [DW-1:0] w;
    logic [AW-1:0] pc;
    logic          oob;
    int            cyc;
    int            st;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req, flush, out_ready, ld_en, stream, d_oob;
  logic [AW-1:0] d_addr, ld_addr;
  logic [DW-1:0] d_exp, ld_data;
  logic [DW-1:0] tbl [6];

  logic          fr  [2];
  logic          ov  [2];
  logic [DW-1:0] oi  [2];
  logic [AW-1:0] opc [2];
  logic          oo  [2];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = g + 1;
    logic          l_req, l_oob;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_exp;
    int            ptr = 0;
    int            stalls = 0;
    item_t         q[$];
    item_t         it;
    bit            held = 1'b0;
    logic [DW-1:0] h_i;
    logic [AW-1:0] h_pc;
    logic          h_o;
`ifdef INSTR_MEM_PARITY_EN
    logic          pe;
`endif

    // Directed vector, or a per-lane PC stream that only advances on accept.
    always_comb begin
      l_req  = stream ? (ptr < 6) : req;
      l_addr = stream ? AW'(10 + ptr) : d_addr;
      l_exp  = stream ? ((ptr < 6) ? tbl[ptr] : '0) : d_exp;
      l_oob  = stream ? 1'b0 : d_oob;
    end

    instr_mem_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT), .HALT_WORD(16'hF000)
    ) u_dut (
      .clk(clk), .rst(rst),
      .fetch_req(l_req), .fetch_addr(l_addr), .fetch_ready(fr[g]),
      .out_valid(ov[g]), .out_ready(out_ready), .out_instr(oi[g]),
      .out_pc(opc[g]), .out_oob(oo[g]),
`ifdef INSTR_MEM_PARITY_EN
      .par_err(pe),
`endif
      .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Push expected response on every accepted request.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        ptr <= 0;
      end else begin
        if (flush) begin
          q.delete();
        end else begin
          if (l_req && fr[g]) q.push_back('{l_exp, l_addr, l_oob, cyc, stalls});
          if (ov[g] && !out_ready) stalls <= stalls + 1;
        end
        if (!stream) ptr <= 0;
        else if (l_req && fr[g] && !flush) ptr <= ptr + 1;
      end
    end

    // Monitor: latency on first presentation, stability while held, data on handshake.
    always @(negedge clk) begin
      if (rst) begin
        held = 1'b0;
      end else if (ov[g]) begin
        if (held) begin
          chk($sformatf("lane%0d hold instr", g), oi[g], h_i);
          chk($sformatf("lane%0d hold pc", g), opc[g], h_pc);
          chk($sformatf("lane%0d hold oob", g), oo[g], h_o);
        end else if (q.size() == 0) begin
          chk($sformatf("lane%0d spurious out_valid", g), ov[g], 1'b0);
        end else begin
          chk($sformatf("lane%0d latency pc=%0d", g, q[0].pc), cyc - q[0].cyc,
              LAT + stalls - q[0].st);
        end
        if (out_ready) begin
          if (q.size() != 0) begin
            it = q.pop_front();
            chk($sformatf("lane%0d instr pc=%0d", g, it.pc), oi[g], it.w);
            chk($sformatf("lane%0d pc", g), opc[g], it.pc);
            chk($sformatf("lane%0d oob pc=%0d", g, it.pc), oo[g], it.oob);
`ifdef INSTR_MEM_PARITY_EN
            chk($sformatf("lane%0d par_err", g), pe, 1'b0);
`endif
          end
          held = 1'b0;
        end else begin
          held = !flush;
          h_i  = oi[g];
          h_pc = opc[g];
          h_o  = oo[g];
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic o);
    req = 1'b1; d_addr = a; d_exp = e; d_oob = o;
    step();
    req = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    tbl = '{16'h1A10, 16'h2B11, 16'h3C12, 16'h4D13, 16'h5E14, 16'h6F15};
    req = 1'b1; d_addr = 8'd7; d_exp = 16'hDEAD; d_oob = 1'b0;
    out_ready = 1'b1; flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    stream = 1'b0;

    // Reset state; a request presented during reset is ignored.
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lane%0d reset fetch_ready", i), fr[i], 1'b1);
      chk($sformatf("lane%0d reset out_valid", i), ov[i], 1'b0);
      chk($sformatf("lane%0d reset out_instr", i), oi[i], 16'h0000);
      chk($sformatf("lane%0d reset out_pc", i), opc[i], 8'h00);
      chk($sformatf("lane%0d reset out_oob", i), oo[i], 1'b0);
    end
    req = 1'b0;
    rst = 1'b0;
    step();

    // Power-up fill, back-to-back fetches.
    fetch(8'd0, 16'hF000, 1'b0);
    fetch(8'd1, 16'hF000, 1'b0);
    fetch(8'd2, 16'hF000, 1'b0);
    idle(4);

    // Loaded program readback.
    load(8'd0, 16'h1123);
    load(8'd1, 16'h2314);
    load(8'd2, 16'hF000);
    fetch(8'd0, 16'h1123, 1'b0);
    fetch(8'd1, 16'h2314, 1'b0);
    fetch(8'd2, 16'hF000, 1'b0);
    idle(4);

    // Write-first bypass, then the stored value.
    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 16'hABCD;
    fetch(8'd5, 16'hABCD, 1'b0);
    ld_en = 1'b0;
    fetch(8'd5, 16'hABCD, 1'b0);
    idle(4);

    // PC stream with a 3-cycle decode stall.
    for (int i = 0; i < 6; i++) load(AW'(10 + i), tbl[i]);
    stream = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      for (int i = 0; i < 2; i++) chk($sformatf("lane%0d stall fetch_ready", i), fr[i], 1'b0);
      step();
    end
    out_ready = 1'b1;
    repeat (10) step();
    stream = 1'b0;
    idle(3);

    // Out of range: HALT_WORD + oob, and an OOB load bypasses/writes nothing.
    ld_en = 1'b1; ld_addr = 8'd210; ld_data = 16'h5555;
    fetch(8'd210, 16'hF000, 1'b1);
    ld_en = 1'b0;
    fetch(8'd0, 16'h1123, 1'b0);
    fetch(8'd1, 16'h2314, 1'b0);
    fetch(8'd5, 16'hABCD, 1'b0);
    fetch(8'd10, 16'h1A10, 1'b0);
    fetch(8'd199, 16'hF000, 1'b0);
    fetch(8'd200, 16'hF000, 1'b1);
    fetch(8'd255, 16'hF000, 1'b1);
    load(8'd199, 16'h0199);
    fetch(8'd199, 16'h0199, 1'b0);
    idle(4);

    // Flush with fetches in flight and the output stalled.
    out_ready = 1'b0;
    req = 1'b1; d_addr = 8'd0; d_exp = 16'h1123; d_oob = 1'b0;
    step();
    d_addr = 8'd1; d_exp = 16'h2314;
    step();
    flush = 1'b1; d_addr = 8'd2; d_exp = 16'hF000;
    step();
    flush = 1'b0; req = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("lane%0d out_valid after flush", i), ov[i], 1'b0);
    out_ready = 1'b1;
    fetch(8'd2, 16'hF000, 1'b0);
    idle(4);

    // Asynchronous reset in the middle of a stream.
    req = 1'b1; d_addr = 8'd0; d_exp = 16'h1123; d_oob = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lane%0d async reset out_valid", i), ov[i], 1'b0);
      chk($sformatf("lane%0d async reset fetch_ready", i), fr[i], 1'b1);
    end
    step();
    req = 1'b0;
    rst = 1'b0;
    step();
    fetch(8'd1, 16'h2314, 1'b0);
    idle(5);

    chk("lane0 leftover expected items", g_lane[0].q.size(), 0);
    chk("lane1 leftover expected items", g_lane[1].q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
Parametrised, clocked instruction memory for the RISC core.
- Replaces the combinational fetch path with a registered read pipeline of configurable latency.
- Fetch requests and returns use a valid/ready handshake, with stall and flush support.
- A load port lets the testbench or boot logic write programs at run time.
- Sits between the PC/fetch stage and the decode stage.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 8, fetch/load address width
DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
HALT_WORD, 16'hF000, power-up fill value and out-of-range return value

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch request valid
fetch_addr  in  ADDR_W  PC address to fetch
fetch_ready  out  1  request accepted this cycle when high
out_valid  out  1  fetched instruction available
out_ready  in  1  decode stage accepts the instruction
out_instr  out  DATA_W  fetched instruction word
out_pc  out  ADDR_W  address the instruction came from
out_oob  out  1  fetch_addr was ≥ DEPTH
flush  in  1  discard all in-flight and held fetches
ld_en  in  1  load-port write enable
ld_addr  in  ADDR_W  load-port address
ld_data  in  DATA_W  load-port data

Behaviour:
Storage and reset
- Storage: DEPTH x DATA_W array, filled with HALT_WORD at time zero.
- rst does not alter the array.
- rst (async) clears all pipeline valid bits. Reset values: out_valid=0, out_instr=0, out_pc=0, out_oob=0.
- fetch_ready is combinational and therefore reads 1 while rst is high. Requests presented during reset are ignored.

Pipeline control
- Pipeline: RD_LAT stages, each holding {valid, instr, pc, oob}. The last stage drives the out_* ports.
- adv = !out_valid || out_ready.
- fetch_ready = adv.
- A request is accepted when fetch_req && fetch_ready && !flush.

Advance and stall
- When adv=1, every stage shifts forward. Stage 0 loads the accept result.
- When adv=0, every stage holds. out_* stay stable until out_ready is seen.
- Latency: an accepted request appears on out_* exactly RD_LAT cycles later, provided no stall occurs.
- Throughput: 1 instruction per cycle.

Read and load rules
- Read data is sampled in the accept cycle.
- If ld_en=1 and ld_addr==fetch_addr in the same cycle, the read returns ld_data (write-first).
- Out-of-range: fetch_addr ≥ DEPTH returns HALT_WORD with oob=1. ld_en with ld_addr ≥ DEPTH is ignored; no write occurs.
- Loads are accepted every cycle regardless of fetch, stall or flush state.

Flush
- flush=1 clears every stage valid on the next edge and blocks acceptance that cycle.
- flush has priority over a stall.
- Next cycle: out_valid=0.

Reset mid-operation
- rst mid-operation drops all in-flight fetches immediately.
- A load in progress on the same edge as reset deassertion is not guaranteed; drive ld_en=0 during rst.

RD_LAT=2
- Stage 0 holds the raw read. Stage 1 is the output register.
- Both stages stall together.

Optional Feature:
INSTR_MEM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, computed on load and on the power-up fill.
  - On read, parity is rechecked.
  - Extra output port par_err (1 bit) is qualified by out_valid and follows the same pipeline/stall timing as out_instr.
  - par_err resets to 0.
  - Out-of-range reads report par_err=0.
- Undefined: no parity storage and no par_err port. Behaviour is otherwise identical.

Test Plan:
1. Reset, then fetch_req=1 with fetch_addr=0,1,2 on consecutive cycles, out_ready=1, RD_LAT=1, no prior loads → out_valid rises 1 cycle after the first accept; out_instr=F000 x3 with out_pc=0,1,2 back-to-back.
2. Load 0x1123 @0, 0x2314 @1, 0xF000 @2, then fetch 0..2 with RD_LAT=2 → out_instr = 1123, 2314, F000, each arriving 2 cycles after its accept.
3. Same cycle ld_en=1, ld_addr=5, ld_data=0xABCD and fetch_addr=5 → out_instr=ABCD. A later fetch of 5 also returns ABCD.
4. Valid output with out_ready=0 for 3 cycles while fetch_req=1 → fetch_ready=0 and out_instr/out_pc held constant; on release, the next PCs follow with none lost or duplicated.
5. DEPTH=200, fetch_addr=210 → out_instr=F000, out_oob=1. ld_en with ld_addr=210 leaves all words 0..199 unchanged.
6. Two fetches in flight (RD_LAT=2), then flush=1 for one cycle → out_valid=0 the next cycle and neither flushed instruction appears. Asserting rst mid-stream forces out_valid=0 asynchronously.
